cs151_fetch: RTL
================

# cs151_fetch

Instruction fetch stage sitting directly upstream of the CS151 instruction controller. Maintains the program counter, issues word requests to instruction memory over a req/ack handshake, and presents one registered 32-bit instruction per cycle on `inst` with a valid flag. A one-entry skid buffer absorbs a memory response that arrives while the downstream stage is stalled. Branch and jump redirects flush all held state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INST`, 32'h0000_0000, value driven on `inst` whenever `inst_valid`=0.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; one clock domain.
- `imem_req`  out  1  fetch request; held high until acked.
- `imem_addr`  out  32  byte address of the requested word; stable while `imem_req`=1.
- `imem_ack`  in  1  memory response; may assert in the same cycle as `imem_req` (zero-wait) or later.
- `imem_rdata`  in  32  instruction word; valid only in the `imem_ack` cycle.
- `stall`  in  1  downstream cannot consume `inst` this cycle.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; sampled when `redirect`=1.
- `inst`  out  32  registered instruction to the controller.
- `inst_valid`  out  1  `inst` holds a real instruction.
- `pc_out`  out  32  address of the instruction on `inst`.

## Operation
- State: `pc`, output register (`inst`, `inst_valid`, `pc_out`), skid register (`skid_inst`, `skid_pc`, `skid_valid`), FSM {IDLE, FETCH, HOLD}.
- Reset values: `pc`=RESET_PC, `inst`=NOP_INST, `inst_valid`=0, `pc_out`=0, `skid_valid`=0, state=IDLE, `imem_req`=0.
- `imem_req`=1 only in FETCH; `imem_addr`=`pc` at all times.
- Consume: the output is consumed on an edge where `inst_valid`=1 and `stall`=0. Slot free = `inst_valid`=0 or consumed.
- IDLE: `imem_req`=0; next state FETCH unconditionally.
- FETCH, no ack: if consumed, `inst_valid`<=0 and `inst`<=NOP_INST; stay.
- FETCH, ack, slot free: `inst`<=`imem_rdata`, `pc_out`<=`pc`, `inst_valid`<=1, `pc`<=`pc`+4; stay.
- FETCH, ack, slot not free: `skid_inst`<=`imem_rdata`, `skid_pc`<=`pc`, `skid_valid`<=1, `pc`<=`pc`+4; go HOLD.
- HOLD: `imem_req`=0. When `stall`=0: output<=skid (valid=1), `skid_valid`<=0; go FETCH. Otherwise hold all state.
- Redirect has priority over every other event, including stall and a same-cycle ack. It sets `pc`<=`redirect_pc`, `inst_valid`<=0, `inst`<=NOP_INST, `skid_valid`<=0, and state<=IDLE. Any ack in the redirect cycle is discarded. The pending request is abandoned, since `imem_req` is low for exactly one cycle before reissue.
- PC arithmetic: 32-bit modulo 2^32 (0xFFFF_FFFC+4=0x0000_0000); low two bits are carried as given, with no alignment check.
- No instruction is dropped or duplicated except by redirect or reset.

## Timing
- After `rst_n` rises, the first edge moves IDLE->FETCH. `imem_req` asserts in the 2nd cycle after release.
- Fetch latency: an ack at edge N makes `inst` valid from edge N to the next update, i.e. visible in cycle N+1.
- Throughput: one instruction per cycle with zero-wait memory and no stall; W wait states give one per W+1 cycles.
- Stall costs: at most one extra response is buffered (skid). After stall release, the skid drains in 1 cycle, then `imem_req` reasserts the following cycle.
- Redirect: one bubble cycle with `imem_req` low. First request to `redirect_pc` occurs in the cycle after the redirect edge +1.
- Reset mid-operation: all state returns to reset values at the next edge regardless of FSM state. An outstanding request is abandoned.

## Test plan
- Reset, zero-wait memory returning `addr`^32'hA5A5_A5A5, stall=0 -> `imem_addr` 0,4,8,...; `inst_valid` rises one cycle after first ack; `pc_out`/`inst` pairs match 0/A5A5_A5A5, 4/A5A5_A5A1, ...
- Ack for addr 4 delayed 3 cycles -> `imem_req`=1 and `imem_addr`=4 held 3 cycles. `inst_valid`=0 during the gap after 0 is consumed, then `inst` shows the word for addr 4.
- Stall high 2 cycles while `inst` holds addr 8 -> ack for 12 captured in skid and `imem_req` drops. On release `inst` is the word for 12, then 16 follows. No loss or duplicate.
- Redirect to 0x100 in the same cycle as an ack for 0x20 -> the 0x20 data is never shown. `inst_valid`=0 next cycle, `imem_req` low one cycle, then `imem_addr`=0x100.
- Redirect to 0xFFFF_FFFC -> after that fetch, `imem_addr`=0x0000_0000 and `pc_out` sequence 0xFFFF_FFFC, 0x0.
- `rst_n` low during an outstanding request with `skid_valid`=1 -> next edge: `imem_req`=0, `inst`=NOP_INST, `inst_valid`=0. Refetch starts at RESET_PC after release.

Source files
------------

// File: rtl/cs151_fetch.sv
// Instruction fetch stage for the CS151 controller: PC, imem req/ack handshake,
// registered instruction output and a one-entry skid buffer for stalled responses.

package cs151_fetch_pkg;
  localparam int unsigned XLEN = 32;

  // Captured instruction word together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

module cs151_fetch
  import cs151_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc_out
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  fetch_entry_t    skid;
  logic            skid_valid;

  // Output slot is free when empty or being consumed on this edge.
  logic slot_free_c;
  logic consumed_c;

  assign consumed_c  = inst_valid & ~stall;
  assign slot_free_c = ~inst_valid | ~stall;

  // The fetch address is always the current PC; it only moves on an ack or redirect.
  assign imem_addr = pc;

  // Fetch FSM, PC, output register and skid buffer; redirect overrides all other events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      pc_out     <= '0;
      skid       <= '0;
      skid_valid <= 1'b0;
    end else if (redirect) begin
      // Any in-flight response is dropped; request stays low for one bubble cycle.
      state      <= IDLE;
      pc         <= redirect_pc;
      imem_req   <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            pc <= pc + PC_STEP;
            if (slot_free_c) begin
              inst       <= imem_rdata;
              pc_out     <= pc;
              inst_valid <= 1'b1;
            end else begin
              // Downstream is stalled on a valid word: park the response.
              skid.word  <= imem_rdata;
              skid.pc    <= pc;
              skid_valid <= 1'b1;
              state      <= HOLD;
              imem_req   <= 1'b0;
            end
          end else if (consumed_c) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
          end
        end

        HOLD: begin
          // Drain the skid into the output once the stall clears.
          if (!stall) begin
            inst       <= skid.word;
            pc_out     <= skid.pc;
            inst_valid <= skid_valid;
            skid_valid <= 1'b0;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
